// File: rtl/easyaxi_rd_arb_pkg.sv
// Shared EASYAXI field widths, codes and types for the N:1 read-channel arbiter.
// The define block doubles as the codebase-wide easyaxi_define set.
`ifndef EASYAXI_DEFINE_V
`define EASYAXI_DEFINE_V
`define AXI_ID_W       4
`define AXI_ADDR_W     32
`define AXI_DATA_W     32
`define AXI_LEN_W      8
`define AXI_SIZE_W     3
`define AXI_BURST_W    2
`define AXI_RESP_W     2
`define AXI_MST_IDX_W  1
`define AXI_BURST_FIXED 2'b00
`define AXI_BURST_INCR  2'b01
`define AXI_BURST_WRAP  2'b10
`define AXI_RESP_OKAY   2'b00
`define AXI_RESP_EXOKAY 2'b01
`define AXI_RESP_SLVERR 2'b10
`define AXI_RESP_DECERR 2'b11
`endif

package easyaxi_rd_arb_pkg;

   localparam int unsigned AXI_ID_W    = `AXI_ID_W;
   localparam int unsigned AXI_ADDR_W  = `AXI_ADDR_W;
   localparam int unsigned AXI_DATA_W  = `AXI_DATA_W;
   localparam int unsigned AXI_LEN_W   = `AXI_LEN_W;
   localparam int unsigned AXI_SIZE_W  = `AXI_SIZE_W;
   localparam int unsigned AXI_BURST_W = `AXI_BURST_W;
   localparam int unsigned AXI_RESP_W  = `AXI_RESP_W;

   typedef enum logic {
      ST_UNLOCKED = 1'b0,
      ST_LOCKED   = 1'b1
   } lock_state_e;

   typedef struct packed {
      logic [AXI_ADDR_W-1:0]  addr;
      logic [AXI_LEN_W-1:0]   len;
      logic [AXI_SIZE_W-1:0]  size;
      logic [AXI_BURST_W-1:0] burst;
   } ar_pld_t;

   // Index width for n requesters; a single requester still needs one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/easyaxi_rr_arb.sv
// Combinational round-robin pick: first asserted request at or above i_ptr, with wrap.
module easyaxi_rr_arb
   import easyaxi_rd_arb_pkg::*;
#(
   parameter  int unsigned N     = 2,
   localparam int unsigned IDX_W = idx_w(N)
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [N-1:0]     o_gnt_oh,
   output logic [IDX_W-1:0] o_gnt_idx,
   output logic             o_any
);

   always_comb begin
      int unsigned k;
      k         = 0;
      o_gnt_oh  = '0;
      o_gnt_idx = '0;
      o_any     = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         k = (int'(i_ptr) + i) % N;
         if (!o_any && i_req[IDX_W'(k)]) begin
            o_any       = 1'b1;
            o_gnt_idx   = IDX_W'(k);
            o_gnt_oh[k] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/easyaxi_rd_arb.sv
// N:1 EASYAXI read arbiter: round-robin AR grant with lock-on-stall, master index
// prepended to ARID, R beats routed back on the upper RID bits, per-master throttle.
module easyaxi_rd_arb
   import easyaxi_rd_arb_pkg::*;
#(
   parameter  int unsigned MST_NUM   = 2,
   parameter  int unsigned OST_MAX   = 16,
   localparam int unsigned MST_IDX_W = idx_w(MST_NUM),
   localparam int unsigned OST_CNT_W = $clog2(OST_MAX + 1),
   localparam int unsigned SID_W     = AXI_ID_W + MST_IDX_W
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [MST_NUM-1:0]             mst_arvalid,
   output logic [MST_NUM-1:0]             mst_arready,
   input  logic [MST_NUM*AXI_ID_W-1:0]    mst_arid,
   input  logic [MST_NUM*AXI_ADDR_W-1:0]  mst_araddr,
   input  logic [MST_NUM*AXI_LEN_W-1:0]   mst_arlen,
   input  logic [MST_NUM*AXI_SIZE_W-1:0]  mst_arsize,
   input  logic [MST_NUM*AXI_BURST_W-1:0] mst_arburst,
   output logic [MST_NUM-1:0]             mst_rvalid,
   input  logic [MST_NUM-1:0]             mst_rready,
   output logic [AXI_ID_W-1:0]            mst_rid,
   output logic [AXI_DATA_W-1:0]          mst_rdata,
   output logic [AXI_RESP_W-1:0]          mst_rresp,
   output logic                           mst_rlast,
   output logic                           slv_arvalid,
   input  logic                           slv_arready,
   output logic [SID_W-1:0]               slv_arid,
   output logic [AXI_ADDR_W-1:0]          slv_araddr,
   output logic [AXI_LEN_W-1:0]           slv_arlen,
   output logic [AXI_SIZE_W-1:0]          slv_arsize,
   output logic [AXI_BURST_W-1:0]         slv_arburst,
   input  logic                           slv_rvalid,
   output logic                           slv_rready,
   input  logic [SID_W-1:0]               slv_rid,
   input  logic [AXI_DATA_W-1:0]          slv_rdata,
   input  logic [AXI_RESP_W-1:0]          slv_rresp,
   input  logic                           slv_rlast,
   output logic                           error
);

   lock_state_e            r_state, w_state_nxt;
   logic [MST_IDX_W-1:0]   r_grant, w_grant_nxt;
   logic [MST_IDX_W-1:0]   r_rr_ptr, w_ptr_nxt;
   logic [OST_CNT_W-1:0]   r_ost_cnt [MST_NUM];
   logic                   r_error;

   logic                   w_lock;
   logic [MST_NUM-1:0]     w_req;
   logic [MST_NUM-1:0]     w_pick_oh;
   logic [MST_IDX_W-1:0]   w_pick_idx;
   logic                   w_pick_any;
   logic [MST_IDX_W-1:0]   w_grant;
   logic [MST_NUM-1:0]     w_grant_oh;
   logic                   w_ar_hs;
   ar_pld_t                w_pld;
   logic [AXI_ID_W-1:0]    w_arid;
   logic [MST_IDX_W-1:0]   w_r_idx;
   logic                   w_idx_ok;
   logic                   w_cnt_nz;
   logic                   w_rr_sel;
   logic                   w_r_ok;
   logic                   w_r_bad;
   logic                   w_r_last_hs;
   logic [MST_NUM-1:0]     w_ost_inc;
   logic [MST_NUM-1:0]     w_ost_dec;

   assign w_lock = (r_state == ST_LOCKED);

   // A master at its outstanding limit drops out of new arbitration only.
   always_comb begin
      w_req = '0;
      for (int unsigned k = 0; k < MST_NUM; k++) begin
         w_req[k] = mst_arvalid[k] & (r_ost_cnt[k] != OST_CNT_W'(OST_MAX));
      end
   end

   easyaxi_rr_arb #(.N(MST_NUM)) u_rr_arb (
      .i_req     (w_req),
      .i_ptr     (r_rr_ptr),
      .o_gnt_oh  (w_pick_oh),
      .o_gnt_idx (w_pick_idx),
      .o_any     (w_pick_any)
   );

   assign w_grant     = w_lock ? r_grant : w_pick_idx;
   assign w_grant_oh  = w_lock ? (MST_NUM'(1) << r_grant) : w_pick_oh;
   assign slv_arvalid = rst_n & (w_lock | w_pick_any);
   assign w_ar_hs     = slv_arvalid & slv_arready;
   assign mst_arready = w_ar_hs ? w_grant_oh : '0;
   assign w_ost_inc   = mst_arready;

   always_comb begin
      w_pld  = '0;
      w_arid = '0;
      for (int unsigned k = 0; k < MST_NUM; k++) begin
         if (w_grant == MST_IDX_W'(k)) begin
            w_pld.addr  = mst_araddr[k*AXI_ADDR_W +: AXI_ADDR_W];
            w_pld.len   = mst_arlen[k*AXI_LEN_W +: AXI_LEN_W];
            w_pld.size  = mst_arsize[k*AXI_SIZE_W +: AXI_SIZE_W];
            w_pld.burst = mst_arburst[k*AXI_BURST_W +: AXI_BURST_W];
            w_arid      = mst_arid[k*AXI_ID_W +: AXI_ID_W];
         end
      end
   end

   assign slv_arid    = {w_grant, w_arid};
   assign slv_araddr  = w_pld.addr;
   assign slv_arlen   = w_pld.len;
   assign slv_arsize  = w_pld.size;
   assign slv_arburst = w_pld.burst;

   // Lock FSM: a stalled offer freezes grant and payload until it is accepted.
   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_ptr_nxt   = r_rr_ptr;
      case (r_state)
         ST_UNLOCKED: begin
            if (slv_arvalid && !slv_arready) begin
               w_state_nxt = ST_LOCKED;
               w_grant_nxt = w_grant;
            end
         end
         ST_LOCKED: begin
            if (slv_arready) w_state_nxt = ST_UNLOCKED;
         end
         default: w_state_nxt = ST_UNLOCKED;
      endcase
      if (w_ar_hs) begin
         w_ptr_nxt = (w_grant == MST_IDX_W'(MST_NUM - 1)) ? '0 : w_grant + MST_IDX_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_UNLOCKED;
         r_grant  <= '0;
         r_rr_ptr <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_grant  <= w_grant_nxt;
         r_rr_ptr <= w_ptr_nxt;
      end
   end

   // R demux; beats for an unknown or idle master are drained and flagged.
   assign w_r_idx = slv_rid[SID_W-1 -: MST_IDX_W];

   always_comb begin
      w_idx_ok = 1'b0;
      w_cnt_nz = 1'b0;
      w_rr_sel = 1'b0;
      for (int unsigned k = 0; k < MST_NUM; k++) begin
         if (w_r_idx == MST_IDX_W'(k)) begin
            w_idx_ok = 1'b1;
            w_cnt_nz = (r_ost_cnt[k] != '0);
            w_rr_sel = mst_rready[k];
         end
      end
   end

   assign w_r_ok      = slv_rvalid & w_idx_ok & w_cnt_nz;
   assign w_r_bad     = slv_rvalid & ~w_r_ok;
   assign slv_rready  = w_r_bad | w_rr_sel;
   assign w_r_last_hs = w_r_ok & slv_rready & slv_rlast;

   always_comb begin
      mst_rvalid = '0;
      w_ost_dec  = '0;
      for (int unsigned k = 0; k < MST_NUM; k++) begin
         mst_rvalid[k] = rst_n & w_r_ok & (w_r_idx == MST_IDX_W'(k));
         w_ost_dec[k]  = w_r_last_hs & (w_r_idx == MST_IDX_W'(k));
      end
   end

   assign mst_rid   = slv_rid[AXI_ID_W-1:0];
   assign mst_rdata = slv_rdata;
   assign mst_rresp = slv_rresp;
   assign mst_rlast = slv_rlast;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < MST_NUM; k++) r_ost_cnt[k] <= '0;
      end else begin
         for (int unsigned k = 0; k < MST_NUM; k++) begin
            if (w_ost_inc[k] && !w_ost_dec[k]) begin
               r_ost_cnt[k] <= r_ost_cnt[k] + OST_CNT_W'(1);
            end else if (w_ost_dec[k] && !w_ost_inc[k]) begin
               r_ost_cnt[k] <= r_ost_cnt[k] - OST_CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_error <= 1'b0;
      else        r_error <= r_error | w_r_bad;
   end

   assign error = r_error;

endmodule

// File: tb/tb_easyaxi_rd_arb.sv
// Bench for easyaxi_rd_arb (2 masters, OST_MAX=2): vector table, directed
// lock/reset sequences, then random traffic against a transaction-level model.
module tb_easyaxi_rd_arb;
   import easyaxi_rd_arb_pkg::*;

   localparam int unsigned NM    = 2;
   localparam int unsigned OSTM  = 2;
   localparam int unsigned SID_W = AXI_ID_W + 1;

   logic                        clk = 1'b0;
   logic                        rst_n;
   logic [NM-1:0]               mst_arvalid, mst_arready, mst_rvalid, mst_rready;
   logic [NM*AXI_ID_W-1:0]      mst_arid;
   logic [NM*AXI_ADDR_W-1:0]    mst_araddr;
   logic [NM*AXI_LEN_W-1:0]     mst_arlen;
   logic [NM*AXI_SIZE_W-1:0]    mst_arsize;
   logic [NM*AXI_BURST_W-1:0]   mst_arburst;
   logic [AXI_ID_W-1:0]         mst_rid;
   logic [AXI_DATA_W-1:0]       mst_rdata;
   logic [AXI_RESP_W-1:0]       mst_rresp;
   logic                        mst_rlast;
   logic                        slv_arvalid, slv_arready;
   logic [SID_W-1:0]            slv_arid;
   logic [AXI_ADDR_W-1:0]       slv_araddr;
   logic [AXI_LEN_W-1:0]        slv_arlen;
   logic [AXI_SIZE_W-1:0]       slv_arsize;
   logic [AXI_BURST_W-1:0]      slv_arburst;
   logic                        slv_rvalid, slv_rready;
   logic [SID_W-1:0]            slv_rid;
   logic [AXI_DATA_W-1:0]       slv_rdata;
   logic [AXI_RESP_W-1:0]       slv_rresp;
   logic                        slv_rlast;
   logic                        error;

   always #5 clk = ~clk;

   easyaxi_rd_arb #(.MST_NUM(NM), .OST_MAX(OSTM)) dut (
      .clk(clk), .rst_n(rst_n),
      .mst_arvalid(mst_arvalid), .mst_arready(mst_arready), .mst_arid(mst_arid),
      .mst_araddr(mst_araddr), .mst_arlen(mst_arlen), .mst_arsize(mst_arsize),
      .mst_arburst(mst_arburst), .mst_rvalid(mst_rvalid), .mst_rready(mst_rready),
      .mst_rid(mst_rid), .mst_rdata(mst_rdata), .mst_rresp(mst_rresp), .mst_rlast(mst_rlast),
      .slv_arvalid(slv_arvalid), .slv_arready(slv_arready), .slv_arid(slv_arid),
      .slv_araddr(slv_araddr), .slv_arlen(slv_arlen), .slv_arsize(slv_arsize),
      .slv_arburst(slv_arburst), .slv_rvalid(slv_rvalid), .slv_rready(slv_rready),
      .slv_rid(slv_rid), .slv_rdata(slv_rdata), .slv_rresp(slv_rresp), .slv_rlast(slv_rlast),
      .error(error)
   );

   int n_chk = 0;
   int n_err = 0;

   // Fixed per-master AR payloads used by the table and directed sequences.
   logic [AXI_ID_W-1:0]   fid   [NM] = '{4'd2, 4'd5};
   logic [AXI_ADDR_W-1:0] faddr [NM] = '{32'h10, 32'h20};
   logic [AXI_LEN_W-1:0]  flen  [NM] = '{8'd3, 8'd1};

   typedef struct {
      logic [1:0] arv;  logic ardy; logic rv; logic ridx; logic rlast; logic [1:0] rrdy;
      logic sarv; logic g; logic [1:0] marr; logic [1:0] mrv; logic srr; logic err;
   } vec_t;

   vec_t tbl [23];

   function automatic vec_t mk(input logic [1:0] arv, input logic ardy, input logic rv,
                               input logic ridx, input logic rlast, input logic [1:0] rrdy,
                               input logic sarv, input logic g, input logic [1:0] marr,
                               input logic [1:0] mrv, input logic srr, input logic err);
      vec_t v;
      v.arv = arv; v.ardy = ardy; v.rv = rv; v.ridx = ridx; v.rlast = rlast; v.rrdy = rrdy;
      v.sarv = sarv; v.g = g; v.marr = marr; v.mrv = mrv; v.srr = srr; v.err = err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_fixed_payload();
      for (int k = 0; k < NM; k++) begin
         mst_arid[k*AXI_ID_W +: AXI_ID_W]       = fid[k];
         mst_araddr[k*AXI_ADDR_W +: AXI_ADDR_W] = faddr[k];
         mst_arlen[k*AXI_LEN_W +: AXI_LEN_W]    = flen[k];
      end
      mst_arsize  = {3'd2, 3'd2};
      mst_arburst = {`AXI_BURST_INCR, `AXI_BURST_INCR};
   endtask

   task automatic drive(input logic [1:0] arv, input logic ardy, input logic rv,
                        input logic ridx, input logic rlast, input logic [1:0] rrdy);
      mst_arvalid = arv;
      slv_arready = ardy;
      slv_rvalid  = rv;
      slv_rid     = {ridx, fid[ridx]};
      slv_rlast   = rlast;
      mst_rready  = rrdy;
      slv_rdata   = $urandom;
      slv_rresp   = AXI_RESP_W'($urandom_range(0, 3));
   endtask

   task automatic check_ar(input string tag, input logic sarv, input logic g, input logic [1:0] marr);
      chk({tag, " slv_arvalid"}, 64'(slv_arvalid), 64'(sarv));
      if (sarv) begin
         chk({tag, " slv_arid"}, 64'(slv_arid), 64'({g, fid[g]}));
         chk({tag, " slv_araddr"}, 64'(slv_araddr), 64'(faddr[g]));
         chk({tag, " slv_arlen"}, 64'(slv_arlen), 64'(flen[g]));
      end
      chk({tag, " mst_arready"}, 64'(mst_arready), 64'(marr));
   endtask

   task automatic check_r(input string tag, input logic [1:0] mrv, input logic srr, input logic err);
      chk({tag, " mst_rvalid"}, 64'(mst_rvalid), 64'(mrv));
      chk({tag, " slv_rready"}, 64'(slv_rready), 64'(srr));
      chk({tag, " error"}, 64'(error), 64'(err));
      chk({tag, " r_payload"}, 64'({mst_rid, mst_rdata, mst_rresp, mst_rlast}),
          64'({slv_rid[AXI_ID_W-1:0], slv_rdata, slv_rresp, slv_rlast}));
   endtask

   task automatic do_reset();
      drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Transaction-level model state for the random phase.
   typedef struct { int idx; logic [AXI_ID_W-1:0] id; int len; } burst_t;

   initial begin
      int            ost [NM];
      int            ptr, held, beat, g, ridx;
      logic [1:0]    arv_q;
      logic          exp_sarv;
      burst_t        pend [$];
      burst_t        b;

      //           arv   rdy rv ri rl rrdy   sarv g  marr   mrv    srr err
      tbl[0]  = mk(2'b00,1, 0, 0, 0, 2'b11,  0,  0, 2'b00, 2'b00, 1,  0);
      tbl[1]  = mk(2'b01,1, 0, 0, 0, 2'b11,  1,  0, 2'b01, 2'b00, 1,  0);
      tbl[2]  = mk(2'b00,1, 1, 0, 0, 2'b11,  0,  0, 2'b00, 2'b01, 1,  0);
      tbl[3]  = mk(2'b00,1, 1, 0, 0, 2'b11,  0,  0, 2'b00, 2'b01, 1,  0);
      tbl[4]  = mk(2'b00,1, 1, 0, 0, 2'b11,  0,  0, 2'b00, 2'b01, 1,  0);
      tbl[5]  = mk(2'b00,1, 1, 0, 1, 2'b11,  0,  0, 2'b00, 2'b01, 1,  0);
      tbl[6]  = mk(2'b11,1, 0, 0, 0, 2'b11,  1,  1, 2'b10, 2'b00, 1,  0);
      tbl[7]  = mk(2'b11,1, 0, 0, 0, 2'b11,  1,  0, 2'b01, 2'b00, 1,  0);
      tbl[8]  = mk(2'b11,1, 0, 0, 0, 2'b11,  1,  1, 2'b10, 2'b00, 1,  0);
      tbl[9]  = mk(2'b11,1, 0, 0, 0, 2'b11,  1,  0, 2'b01, 2'b00, 1,  0);
      tbl[10] = mk(2'b11,1, 0, 0, 0, 2'b11,  0,  0, 2'b00, 2'b00, 1,  0);
      tbl[11] = mk(2'b00,1, 1, 0, 1, 2'b11,  0,  0, 2'b00, 2'b01, 1,  0);
      tbl[12] = mk(2'b11,0, 0, 0, 0, 2'b11,  1,  0, 2'b00, 2'b00, 1,  0);
      tbl[13] = mk(2'b11,0, 1, 1, 1, 2'b01,  1,  0, 2'b00, 2'b10, 0,  0);
      tbl[14] = mk(2'b11,0, 1, 1, 1, 2'b11,  1,  0, 2'b00, 2'b10, 1,  0);
      tbl[15] = mk(2'b11,1, 1, 0, 1, 2'b11,  1,  0, 2'b01, 2'b01, 1,  0);
      tbl[16] = mk(2'b11,1, 0, 0, 0, 2'b11,  1,  1, 2'b10, 2'b00, 1,  0);
      tbl[17] = mk(2'b11,1, 0, 0, 0, 2'b11,  1,  0, 2'b01, 2'b00, 1,  0);
      tbl[18] = mk(2'b00,1, 1, 1, 1, 2'b11,  0,  0, 2'b00, 2'b10, 1,  0);
      tbl[19] = mk(2'b00,1, 1, 1, 1, 2'b11,  0,  0, 2'b00, 2'b10, 1,  0);
      tbl[20] = mk(2'b00,1, 1, 1, 1, 2'b00,  0,  0, 2'b00, 2'b00, 1,  0);
      tbl[21] = mk(2'b00,1, 0, 0, 0, 2'b00,  0,  0, 2'b00, 2'b00, 0,  1);
      tbl[22] = mk(2'b00,1, 1, 0, 1, 2'b11,  0,  0, 2'b00, 2'b01, 1,  1);

      // Reset: outputs quiet even while inputs are active.
      set_fixed_payload();
      rst_n = 1'b0;
      drive(2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11);
      @(negedge clk);
      check_ar("reset", 1'b0, 1'b0, 2'b00);
      chk("reset mst_rvalid", 64'(mst_rvalid), 64'(0));
      chk("reset error", 64'(error), 64'(0));
      do_reset();

      foreach (tbl[i]) begin
         drive(tbl[i].arv, tbl[i].ardy, tbl[i].rv, tbl[i].ridx, tbl[i].rlast, tbl[i].rrdy);
         @(negedge clk);
         check_ar($sformatf("row%0d", i), tbl[i].sarv, tbl[i].g, tbl[i].marr);
         check_r($sformatf("row%0d", i), tbl[i].mrv, tbl[i].srr, tbl[i].err);
         @(posedge clk);
         #1;
      end

      // Asynchronous reset mid-burst with m1 locked and error set.
      drive(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11);
      @(negedge clk);
      check_ar("prerst", 1'b1, 1'b1, 2'b00);
      check_r("prerst", 2'b01, 1'b1, 1'b1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_ar("asyncrst", 1'b0, 1'b0, 2'b00);
      chk("asyncrst mst_rvalid", 64'(mst_rvalid), 64'(0));
      chk("asyncrst error", 64'(error), 64'(0));
      @(posedge clk);
      #1;
      drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      rst_n = 1'b1;
      // Pointer back at 0 and counters cleared: m0 first, two grants, then throttled.
      drive(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11);
      @(negedge clk);
      check_ar("postrst0", 1'b1, 1'b0, 2'b01);
      check_r("postrst0", 2'b00, 1'b1, 1'b0);
      @(posedge clk);
      #1 drive(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11);
      @(negedge clk);
      check_ar("postrst1", 1'b1, 1'b0, 2'b01);
      @(posedge clk);
      #1 drive(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11);
      @(negedge clk);
      check_ar("postrst2", 1'b0, 1'b0, 2'b00);
      @(posedge clk);
      #1;

      // Backpressure: m1 offer held while m0 arrives; m0 served only afterwards.
      do_reset();
      for (int c = 0; c < 5; c++) begin
         drive((c == 0) ? 2'b10 : 2'b11, (c >= 3) ? 1'b1 : 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
         @(negedge clk);
         if (c < 3)       check_ar($sformatf("bp%0d", c), 1'b1, 1'b1, 2'b00);
         else if (c == 3) check_ar($sformatf("bp%0d", c), 1'b1, 1'b1, 2'b10);
         else             check_ar($sformatf("bp%0d", c), 1'b1, 1'b0, 2'b01);
         @(posedge clk);
         #1;
      end

      // Random traffic against the transaction-level model.
      do_reset();
      ost[0] = 0; ost[1] = 0; ptr = 0; held = -1; beat = 0; arv_q = 2'b00;
      for (int c = 0; c < 600; c++) begin
         for (int k = 0; k < NM; k++) begin
            if (!arv_q[k] && $urandom_range(0, 1) == 1) begin
               arv_q[k] = 1'b1;
               mst_arid[k*AXI_ID_W +: AXI_ID_W]       = AXI_ID_W'($urandom);
               mst_araddr[k*AXI_ADDR_W +: AXI_ADDR_W] = $urandom;
               mst_arlen[k*AXI_LEN_W +: AXI_LEN_W]    = AXI_LEN_W'($urandom_range(0, 3));
               mst_arsize[k*AXI_SIZE_W +: AXI_SIZE_W] = AXI_SIZE_W'($urandom_range(0, 2));
            end
         end
         mst_arvalid = arv_q;
         slv_arready = 1'($urandom_range(0, 1));
         mst_rready  = 2'($urandom_range(0, 3));
         slv_rdata   = $urandom;
         slv_rresp   = AXI_RESP_W'($urandom_range(0, 3));
         if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
            slv_rvalid = 1'b1;
            slv_rid    = {1'(pend[0].idx), pend[0].id};
            slv_rlast  = (beat == pend[0].len);
         end else begin
            slv_rvalid = 1'b0;
            slv_rid    = SID_W'($urandom);
            slv_rlast  = 1'b0;
         end
         @(negedge clk);
         g = held;
         if (g < 0) begin
            for (int i = 0; i < NM; i++) begin
               int k;
               k = (ptr + i) % NM;
               if (g < 0 && arv_q[k] && ost[k] < OSTM) g = k;
            end
         end
         exp_sarv = (g >= 0);
         chk($sformatf("rnd%0d slv_arvalid", c), 64'(slv_arvalid), 64'(exp_sarv));
         if (exp_sarv) begin
            chk($sformatf("rnd%0d slv_arid", c), 64'(slv_arid),
                64'({1'(g), mst_arid[g*AXI_ID_W +: AXI_ID_W]}));
            chk($sformatf("rnd%0d slv_ar_pld", c), 64'({slv_araddr, slv_arlen, slv_arsize}),
                64'({mst_araddr[g*AXI_ADDR_W +: AXI_ADDR_W], mst_arlen[g*AXI_LEN_W +: AXI_LEN_W],
                     mst_arsize[g*AXI_SIZE_W +: AXI_SIZE_W]}));
         end
         chk($sformatf("rnd%0d mst_arready", c), 64'(mst_arready),
             64'((exp_sarv && slv_arready) ? (2'b01 << g) : 2'b00));
         ridx = int'(slv_rid[SID_W-1]);
         check_r($sformatf("rnd%0d", c), slv_rvalid ? (2'b01 << ridx) : 2'b00,
                 mst_rready[ridx], 1'b0);
         @(posedge clk);
         if (exp_sarv && slv_arready) begin
            ost[g]++;
            ptr      = (g + 1) % NM;
            held     = -1;
            arv_q[g] = 1'b0;
            b.idx = g;
            b.id  = mst_arid[g*AXI_ID_W +: AXI_ID_W];
            b.len = int'(mst_arlen[g*AXI_LEN_W +: AXI_LEN_W]);
            pend.push_back(b);
         end else if (exp_sarv) begin
            held = g;
         end
         if (slv_rvalid && mst_rready[ridx]) begin
            if (slv_rlast) begin
               ost[ridx]--;
               void'(pend.pop_front());
               beat = 0;
            end else begin
               beat++;
            end
         end
         #1;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
